// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Latency: n/a (types only).
// Backpressure: n/a.
package barrel_shifter_pkg;

    typedef enum logic [1:0] {
        SHL = 2'd0,
        SHR = 2'd1,
        SAR = 2'd2,
        ROL = 2'd3
    } shift_mode_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One shifter stage: conditional shift by SHIFT (SHL/SHR/SAR/ROL) into a valid/ready register slice.
// Latency: 1 cycle.
// Backpressure: loads when empty or downstream ready; sticky ports exist only with BARREL_SHIFTER_STICKY_EN.
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4,
    parameter int L     = $clog2(N),
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             up_valid,
    input  logic [N-1:0]     up_data,
    input  logic [L-1:0]     up_amt,
    input  shift_mode_t      up_mode,
    input  logic [TAG_W-1:0] up_tag,
`ifdef BARREL_SHIFTER_STICKY_EN
    input  logic             up_sticky,
    output logic             dn_sticky,
`endif
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [N-1:0]     dn_data,
    output logic [L-1:0]     dn_amt,
    output shift_mode_t      dn_mode,
    output logic [TAG_W-1:0] dn_tag
);

    localparam int B = $clog2(SHIFT);

    logic         en;
    logic         load;
    logic [N-1:0] nxt;

    assign en   = up_amt[B];
    assign load = !dn_valid || dn_ready;

    always_comb begin
        nxt = up_data;
        if (en) begin
            unique case (up_mode)
                SHL: nxt = up_data << SHIFT;
                SHR: nxt = up_data >> SHIFT;
                SAR: nxt = $unsigned($signed(up_data) >>> SHIFT);
                ROL: nxt = (up_data << SHIFT) | (up_data >> (N - SHIFT));
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_amt   <= '0;
            dn_mode  <= SHL;
            dn_tag   <= '0;
        end else if (load) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= nxt;
                dn_amt  <= up_amt;
                dn_mode <= up_mode;
                dn_tag  <= up_tag;
            end
        end
    end

`ifdef BARREL_SHIFTER_STICKY_EN
    logic disc;

    // Bits pushed off the end by this stage; rotation never loses any.
    always_comb begin
        disc = 1'b0;
        if (en) begin
            unique case (up_mode)
                SHL:      disc = |up_data[N-1 -: SHIFT];
                SHR, SAR: disc = |up_data[SHIFT-1:0];
                ROL:      disc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dn_sticky <= 1'b0;
        end else if (load && up_valid) begin
            dn_sticky <= up_sticky | disc;
        end
    end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (SHL/SHR/SAR/ROL), L=$clog2(N) stages, largest shift first; BARREL_SHIFTER_STICKY_EN adds sticky.
// Latency: L cycles, one result per clock.
// Backpressure: per-stage elastic valid/ready; bubbles collapse, in_ready drops only when every stage is full and stalled.
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int TAG_W = 4,
    localparam int L     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [L-1:0]     in_amt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sticky
);

    logic [L:0]            vld;
    logic [L:0]            rdy;
    logic [L:0][N-1:0]     dat;
    logic [L:0][L-1:0]     amt;
    logic [L:0][TAG_W-1:0] tag;
    shift_mode_t           mode [L+1];

    assign vld[0]  = in_valid;
    assign dat[0]  = in_data;
    assign amt[0]  = in_amt;
    assign mode[0] = shift_mode_t'(in_mode);
    assign tag[0]  = in_tag;

    // Ready ripples back from the output; stage k feeds the slice at index k+1.
    always_comb begin
        rdy[L] = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[L];
    assign out_data  = dat[L];
    assign out_tag   = tag[L];

`ifdef BARREL_SHIFTER_STICKY_EN
    logic [L:0] stk;
    assign stk[0]     = 1'b0;
    assign out_sticky = stk[L];
`else
    assign out_sticky = 1'b0;
`endif

    // The final stage's amount and mode have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt[L], mode[L]};

    for (genvar k = 0; k < L; k++) begin : g_stage
        barrel_shift_stage #(
            .N     (N),
            .TAG_W (TAG_W),
            .L     (L),
            .SHIFT (1 << (L - 1 - k))
        ) u_stage (
            .clk       (clk),
            .rstN      (rstN),
            .up_valid  (vld[k]),
            .up_data   (dat[k]),
            .up_amt    (amt[k]),
            .up_mode   (mode[k]),
            .up_tag    (tag[k]),
`ifdef BARREL_SHIFTER_STICKY_EN
            .up_sticky (stk[k]),
            .dn_sticky (stk[k+1]),
`endif
            .dn_valid  (vld[k+1]),
            .dn_ready  (rdy[k+1]),
            .dn_data   (dat[k+1]),
            .dn_amt    (amt[k+1]),
            .dn_mode   (mode[k+1]),
            .dn_tag    (tag[k+1])
        );
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: N=8 directed/random scenarios plus an N=32 random sweep against an arithmetic model.
// Latency: n/a.
// Backpressure: out_ready is driven directly by the scenarios.
module tb_pipelined_barrel_shifter;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_sticky;
    logic [7:0] in_data = '0, out_data;
    logic [2:0] in_amt = '0;
    logic [1:0] in_mode = '0;
    logic [3:0] in_tag = '0, out_tag;

    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0, w_out_sticky;
    logic [31:0] w_in_data = '0, w_out_data;
    logic [4:0]  w_in_amt = '0;
    logic [1:0]  w_in_mode = '0;
    logic [3:0]  w_in_tag = '0, w_out_tag;

    pipelined_barrel_shifter #(.N(8), .TAG_W(4)) u8 (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_sticky(out_sticky)
    );

    pipelined_barrel_shifter #(.N(32), .TAG_W(4)) u32 (
        .clk(clk), .rstN(rstN), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_amt(w_in_amt), .in_mode(w_in_mode), .in_tag(w_in_tag), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .out_tag(w_out_tag), .out_sticky(w_out_sticky)
    );

    typedef struct { logic [7:0] d; logic [3:0] t; logic s; int c; } exp8_t;
    typedef struct { logic [31:0] d; logic [3:0] t; logic s; } exp32_t;

    exp8_t  q8[$];
    exp32_t q32[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       acc, fired, got_ir, got_ov, got_s, exp_s;
    logic [7:0] got_d, exp_d;
    logic [3:0] got_t, exp_t;
    int         lat;

    // Reference: shift an n-bit value with plain wide arithmetic.
    function automatic void ref_op(input int n, input logic [31:0] d, input int a, input logic [1:0] m,
                                   output logic [31:0] r, output logic s);
        logic [63:0] dd, mask, low;
        mask = (64'd1 << n) - 64'd1;
        dd   = {32'd0, d} & mask;
        low  = (64'd1 << a) - 64'd1;
        r = '0;
        s = 1'b0;
        case (m)
            2'd0: begin r = 32'((dd << a) & mask); s = (a > 0) && ((dd >> (n - a)) != 0); end
            2'd1: begin r = 32'(dd >> a); s = (dd & low) != 0; end
            2'd2: begin
                r = 32'((dd >> a) | (dd[n-1] ? (mask & ~(mask >> a)) : 64'd0));
                s = (dd & low) != 0;
            end
            default: r = 32'(((dd << a) | (dd >> (n - a))) & mask);
        endcase
`ifndef BARREL_SHIFTER_STICKY_EN
        s = 1'b0;
`endif
    endfunction

    // Drive one cycle on the N=8 DUT, sample just before the next rising edge, and update the scoreboard.
    task automatic step8(input bit v, input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                         input logic [3:0] t, input bit ordy);
        logic [31:0] r;
        logic        s;
        exp8_t       e;
        @(negedge clk);
        in_valid = v; in_data = d; in_amt = a; in_mode = m; in_tag = t; out_ready = ordy;
        #2;
        cyc++;
        got_ir = in_ready; got_ov = out_valid; got_d = out_data; got_t = out_tag; got_s = out_sticky;
        acc   = v && in_ready && rstN;
        fired = out_valid && out_ready && rstN;
        if (fired) begin
            if (q8.size() > 0) begin
                e = q8.pop_front();
                exp_d = e.d; exp_t = e.t; exp_s = e.s; lat = cyc - e.c;
            end else begin
                exp_d = 'x; exp_t = 'x; exp_s = 1'bx; lat = -1;
            end
        end
        if (acc) begin
            ref_op(8, {24'd0, d}, int'(a), m, r, s);
            e.d = r[7:0]; e.t = t; e.s = s; e.c = cyc;
            q8.push_back(e);
        end
    endtask

    task automatic test_reset();
        int fires = 0;
        for (int i = 0; i < 2; i++) begin
            step8(1'b1, 8'hB4, 3'd3, 2'd0, 4'h9, 1'b1);
            checks++;
            if (got_ov !== 1'b0 || got_d !== 8'h00 || got_s !== 1'b0 || got_t !== 4'h0) begin
                errors++;
                $display("FAIL reset_state: valid=%b data=%h sticky=%b tag=%h, want all zero", got_ov, got_d, got_s, got_t);
            end
        end
        step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
        rstN = 1'b1;
        step8(1'b1, 8'hB4, 3'd1, 2'd0, 4'h5, 1'b1);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_accept: in_ready=%b, want 1", got_ir);
        end
        for (int i = 0; i < 5; i++) begin
            step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
            if (fired) begin
                fires++;
                checks++;
                if (lat != 3 || got_d !== exp_d || got_t !== exp_t || got_s !== exp_s) begin
                    errors++;
                    $display("FAIL reset_first_op: latency=%0d data=%h tag=%h sticky=%b, want 3 %h %h %b", lat, got_d, got_t, got_s, exp_d, exp_t, exp_s);
                end
            end
        end
        checks++;
        if (fires != 1) begin
            errors++;
            $display("FAIL reset_first_count: %0d results, want 1", fires);
        end
    endtask

    task automatic test_midreset();
        int fires = 0;
        for (int i = 0; i < 4; i++) step8(1'b1, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'(i), 1'b0);
        rstN = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flush: out_valid=%b out_data=%h in_ready=%b, want 0 00 1", out_valid, out_data, in_ready);
        end
        q8.delete();
        step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
        rstN = 1'b1;
        step8(1'b1, 8'h81, 3'd2, 2'd2, 4'hC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
            if (fired) begin
                fires++;
                checks++;
                if (got_d !== exp_d || got_t !== exp_t || got_s !== exp_s) begin
                    errors++;
                    $display("FAIL midreset_op: data=%h tag=%h sticky=%b, want %h %h %b", got_d, got_t, got_s, exp_d, exp_t, exp_s);
                end
            end
        end
        checks++;
        if (fires != 1) begin
            errors++;
            $display("FAIL midreset_count: %0d results, want 1 (no replay)", fires);
        end
    endtask

    task automatic test_modes();
        logic [7:0] sd [8];
        logic       ss [8];
        int         k = 0;
        sd = '{8'hA0, 8'h16, 8'hF6, 8'hA5, 8'hB4, 8'hB4, 8'hB4, 8'hB4};
        ss = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifndef BARREL_SHIFTER_STICKY_EN
        foreach (ss[i]) ss[i] = 1'b0;
`endif
        for (int i = 0; i < 12; i++) begin
            step8(i < 8, 8'hB4, (i < 4) ? 3'd3 : 3'd0, 2'(i % 4), 4'(i), 1'b1);
            if (fired) begin
                checks++;
                if (k >= 8 || got_d !== sd[k % 8] || got_s !== ss[k % 8] || got_t !== 4'(k)) begin
                    errors++;
                    $display("FAIL modes[%0d]: data=%h sticky=%b tag=%h, want %h %b %h", k, got_d, got_s, got_t, sd[k % 8], ss[k % 8], 4'(k));
                end
                k++;
            end
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL modes_count: %0d results, want 8", k);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int acc0 = 0;
        for (int i = 0; i < 20; i++) begin
            step8(i < 16, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'(i), 1'b1);
            if (acc && i == 0) acc0 = cyc;
            if (fired) begin
                checks++;
                if (got_d !== exp_d || got_s !== exp_s || got_t !== 4'(k) || lat != 3 || cyc != acc0 + 3 + k) begin
                    errors++;
                    $display("FAIL stream[%0d]: data=%h sticky=%b tag=%h lat=%0d cyc=%0d, want %h %b %h 3 %0d", k, got_d, got_s, got_t, lat, cyc, exp_d, exp_s, 4'(k), acc0 + 3 + k);
                end
                k++;
            end
        end
        checks++;
        if (k != 16 || q8.size() != 0) begin
            errors++;
            $display("FAIL stream_count: %0d results, %0d left, want 16 and 0", k, q8.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_d;
        logic [3:0] hold_t;
        for (int i = 0; i < 3; i++) begin
            step8(1'b1, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'(i), 1'b0);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill[%0d]: in_ready=%b, want 1", i, got_ir);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step8(1'b1, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'hF, 1'b0);
            if (i == 0) begin hold_d = got_d; hold_t = got_t; end
            checks++;
            if (got_ir !== 1'b0 || got_ov !== 1'b1 || got_d !== hold_d || got_t !== hold_t) begin
                errors++;
                $display("FAIL bp_stall[%0d]: in_ready=%b valid=%b data=%h tag=%h, want 0 1 %h %h", i, got_ir, got_ov, got_d, got_t, hold_d, hold_t);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step8(i < 6, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'(3 + i), 1'b1);
            if (i == 0) begin
                checks++;
                if (got_ir !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_release_ready: in_ready=%b, want 1", got_ir);
                end
            end
            if (fired) begin
                checks++;
                if (got_d !== exp_d || got_t !== exp_t || got_s !== exp_s) begin
                    errors++;
                    $display("FAIL bp_drain: data=%h tag=%h sticky=%b, want %h %h %b", got_d, got_t, got_s, exp_d, exp_t, exp_s);
                end
            end
        end
        checks++;
        if (q8.size() != 0) begin
            errors++;
            $display("FAIL bp_lost: %0d operations never emerged, want 0", q8.size());
        end
    endtask

    task automatic test_bubble();
        int n_acc = 0;
        int fires = 0;
        step8(1'b1, 8'h5A, 3'd5, 2'd3, 4'h1, 1'b1);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
        step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step8(1'b1, 8'($urandom()), 3'($urandom()), 2'($urandom()), 4'(2 + i), 1'b0);
            if (acc) n_acc++;
        end
        checks++;
        if (n_acc != 2 || got_ir !== 1'b0 || got_ov !== 1'b1) begin
            errors++;
            $display("FAIL bubble_fill: accepted=%0d in_ready=%b out_valid=%b, want 2 0 1", n_acc, got_ir, got_ov);
        end
        for (int i = 0; i < 6; i++) begin
            step8(1'b0, 8'h00, 3'd0, 2'd0, 4'h0, 1'b1);
            if (fired) begin
                fires++;
                checks++;
                if (got_d !== exp_d || got_t !== exp_t || got_s !== exp_s) begin
                    errors++;
                    $display("FAIL bubble_drain: data=%h tag=%h sticky=%b, want %h %h %b", got_d, got_t, got_s, exp_d, exp_t, exp_s);
                end
            end
        end
        checks++;
        if (fires != 3) begin
            errors++;
            $display("FAIL bubble_count: %0d results, want 3", fires);
        end
    endtask

    task automatic test_sweep32();
        exp32_t      e;
        logic [31:0] r;
        logic        s;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            w_in_valid  = (i < 400) && (i < 8 || $urandom_range(0, 3) != 0);
            w_in_data   = $urandom();
            w_in_amt    = (i < 8) ? 5'((i % 2) * 31) : 5'($urandom());
            w_in_mode   = (i < 8) ? 2'((i / 2) % 4) : 2'($urandom());
            w_in_tag    = 4'(i);
            w_out_ready = (i >= 400) || ($urandom_range(0, 3) != 0);
            #2;
            if (w_out_valid && w_out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL sweep32_extra: data=%h tag=%h with nothing outstanding", w_out_data, w_out_tag);
                end else begin
                    e = q32.pop_front();
                    if (w_out_data !== e.d || w_out_tag !== e.t || w_out_sticky !== e.s) begin
                        errors++;
                        $display("FAIL sweep32: data=%h tag=%h sticky=%b, want %h %h %b", w_out_data, w_out_tag, w_out_sticky, e.d, e.t, e.s);
                    end
                end
            end
            if (w_in_valid && w_in_ready) begin
                ref_op(32, w_in_data, int'(w_in_amt), w_in_mode, r, s);
                e.d = r; e.t = w_in_tag; e.s = s;
                q32.push_back(e);
            end
        end
        checks++;
        if (q32.size() != 0) begin
            errors++;
            $display("FAIL sweep32_drain: %0d operations never emerged, want 0", q32.size());
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_midreset();
        test_sweep32();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
